// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, FSM state encodings and register-index width
package pipe_pkg;

  // Register-file index width (32 architectural registers)
  localparam int REG_IDX_W = 5;

  // NOOP operation loaded into pipeline registers on bubble and at reset
  localparam logic [5:0] OP_NOOP = 6'b111111;

  // Stall/flush sequencer states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between EX and ID
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  // A load writing $zero never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 br_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 idex_we,
  output logic                 exmem_we,
  output logic                 memwb_we,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 memwb_bubble,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  state_t           state;
  logic [7:0]       wait_cnt;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_q;
  logic             load_use;
  logic             mem_miss;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_miss     = dmem_req && !dmem_ready;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

  // Write-enable and bubble decode: memory freeze outranks load-use, which outranks branch flush
  always_comb begin
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    idex_we      = 1'b0;
    exmem_we     = 1'b0;
    memwb_we     = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (mem_miss) begin
            // MEM/WB keeps moving so the stalled access does not write back twice
            memwb_we     = 1'b1;
            memwb_bubble = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID; the branch in ID, if any, re-resolves next cycle
            idex_we     = 1'b1;
            exmem_we    = 1'b1;
            memwb_we    = 1'b1;
            idex_bubble = 1'b1;
          end else begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            idex_we    = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
            ifid_flush = br_taken;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            memwb_we = 1'b1;
          end else begin
            memwb_we     = 1'b1;
            memwb_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with wait counter and sticky timeout error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_miss) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TIMEOUT) begin
              state     <= ST_ERR;
              mem_err_q <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_we && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  localparam logic [8:0] C_OFF = 9'h000;
  localparam logic [8:0] C_RUN = 9'h1F0;
  localparam logic [8:0] C_FRZ = 9'h012;
  localparam logic [8:0] C_LU  = 9'h074;
  localparam logic [8:0] C_BR  = 9'h1F8;
  localparam logic [8:0] C_ERR = 9'h001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       ex_mem_read = 1'b0, br_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;

  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, memwb_bubble, mem_err;
  logic [15:0] stall_cycles;
  logic pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s, ifid_flush_s, idex_bubble_s;
  logic memwb_bubble_s, mem_err_s;
  logic [3:0] stall_cycles_s;

  logic [8:0] ctl, ctl_s;
  assign ctl   = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, memwb_bubble, mem_err};
  assign ctl_s = {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s, ifid_flush_s, idex_bubble_s,
                  memwb_bubble_s, mem_err_s};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [8:0]  exp_ctl, exp_ctl_s;
  logic [15:0] exp_st;
  logic [3:0]  exp_st_s;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
    .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(pc_we_s),
    .ifid_we(ifid_we_s), .idex_we(idex_we_s), .exmem_we(exmem_we_s), .memwb_we(memwb_we_s),
    .ifid_flush(ifid_flush_s), .idex_bubble(idex_bubble_s), .memwb_bubble(memwb_bubble_s),
    .mem_err(mem_err_s), .stall_cycles(stall_cycles_s)
  );

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic mr, input logic br, input logic req, input logic rdy);
    id_rs = rs; id_rt = rt; ex_rd = rd; ex_mem_read = mr; br_taken = br; dmem_req = req; dmem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (ctl !== C_OFF) begin n_fail++; $display("FAIL reset_ctl got %h exp %h", ctl, C_OFF); end
    n_checks++;
    if (ctl_s !== C_OFF) begin n_fail++; $display("FAIL reset_ctl_s got %h exp %h", ctl_s, C_OFF); end
    n_checks++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL release_run got %h exp %h", ctl, C_RUN); end
    tick();
    n_checks++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL release_stall got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs got %h exp %h", ctl, C_LU); end
    tick();
    n_checks++;
    if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_stall1 got %0d exp 1", stall_cycles); end
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_rd_zero got %h exp %h", ctl, C_RUN); end
    tick();
    drive(5'd2, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rt got %h exp %h", ctl, C_LU); end
    tick();
    drive(5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_no_load got %h exp %h", ctl, C_RUN); end
    drive(5'd4, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_no_match got %h exp %h", ctl, C_RUN); end
    tick();
    n_checks++;
    if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL lu_stall2 got %0d exp 2", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (ctl !== C_FRZ) begin n_fail++; $display("FAIL mw_freeze%0d got %h exp %h", i, ctl, C_FRZ); end
      tick();
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL mw_ready got %h exp %h", ctl, C_RUN); end
    tick();
    n_checks++;
    if (stall_cycles !== 16'd3) begin n_fail++; $display("FAIL mw_stall got %0d exp 3", stall_cycles); end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL mw_back_run got %h exp %h", ctl, C_RUN); end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL mw_same_cycle got %h exp %h", ctl, C_RUN); end
    tick();
    drive(5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ctl !== C_FRZ) begin n_fail++; $display("FAIL mw_priority got %h exp %h", ctl, C_FRZ); end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL mw_ready2 got %h exp %h", ctl, C_RUN); end
    tick();
    n_checks++;
    if (stall_cycles !== 16'd4) begin n_fail++; $display("FAIL mw_stall2 got %0d exp 4", stall_cycles); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_BR) begin n_fail++; $display("FAIL br_flush got %h exp %h", ctl, C_BR); end
    tick();
    drive(5'd12, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL br_with_lu got %h exp %h", ctl, C_LU); end
    tick();
    n_checks++;
    if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL br_stall got %0d exp 1", stall_cycles); end
    drive(5'd12, 5'd0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_BR) begin n_fail++; $display("FAIL br_retry got %h exp %h", ctl, C_BR); end
    tick();
  endtask

  task automatic run_timeout_cycle();
    exp_ctl_s = (cyc <= 5) ? C_FRZ : C_ERR;
    exp_ctl   = (cyc <= 16) ? C_FRZ : C_ERR;
    exp_st    = 16'(cyc - 1);
    exp_st_s  = (cyc - 1 > 15) ? 4'd15 : 4'(cyc - 1);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ctl_s !== exp_ctl_s) begin n_fail++; $display("FAIL to4_ctl c%0d got %h exp %h", cyc, ctl_s, exp_ctl_s); end
    n_checks++;
    if (ctl !== exp_ctl) begin n_fail++; $display("FAIL to15_ctl c%0d got %h exp %h", cyc, ctl, exp_ctl); end
    n_checks++;
    if (stall_cycles_s !== exp_st_s) begin
      n_fail++; $display("FAIL sat_cnt c%0d got %0d exp %0d", cyc, stall_cycles_s, exp_st_s);
    end
    n_checks++;
    if (stall_cycles !== exp_st) begin n_fail++; $display("FAIL to_cnt c%0d got %0d exp %0d", cyc, stall_cycles, exp_st); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      cyc = c;
      run_timeout_cycle();
    end
  endtask

  task automatic test_saturation();
    for (int c = 9; c <= 30; c++) begin
      cyc = c;
      run_timeout_cycle();
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ctl_s !== C_ERR) begin n_fail++; $display("FAIL err_sticky got %h exp %h", ctl_s, C_ERR); end
    tick();
    n_checks++;
    if (ctl !== C_ERR) begin n_fail++; $display("FAIL err_sticky15 got %h exp %h", ctl, C_ERR); end
    n_checks++;
    if (stall_cycles_s !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d exp 15", stall_cycles_s); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl_s !== C_OFF) begin n_fail++; $display("FAIL err_rst_ctl got %h exp %h", ctl_s, C_OFF); end
    n_checks++;
    if (stall_cycles_s !== 4'd0) begin n_fail++; $display("FAIL err_rst_cnt got %0d exp 0", stall_cycles_s); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_OFF) begin n_fail++; $display("FAIL mid_rst_ctl got %h exp %h", ctl, C_OFF); end
    n_checks++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d exp 0", stall_cycles); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL mid_rst_run got %h exp %h", ctl, C_RUN); end
    tick();
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL mid_rst_run2 got %h exp %h", ctl, C_RUN); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
